// File: rtl/usart_tx.sv
// rtl/usart_tx.sv - 8N1/8N2 asynchronous serial transmitter with a one-entry holding register
// Bytes go out LSB-first on tx_pin; a byte waiting in hold follows the stop bit with no idle gap.
module usart_tx #(
  parameter int CLOCKS_PER_BIT = 16,
  parameter int STOP_BITS      = 1
) (
  input  logic       comm_clock,
  input  logic       reset_n,
  input  logic [7:0] data_in,
  input  logic       send,
  output logic       ready,
  output logic       busy,
  output logic       tx_pin
);

  localparam int              CW        = $clog2(CLOCKS_PER_BIT);
  localparam logic [CW-1:0]   BAUD_LAST = CW'(CLOCKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA_BIT,
    STOP_BIT
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] baud_cnt, baud_cnt_nx;
  logic [2:0]    bit_cnt, bit_cnt_nx;
  logic          stop_cnt, stop_cnt_nx;
  logic [7:0]    shift, shift_nx;
  logic [7:0]    hold, hold_nx;
  logic          hold_valid, hold_valid_nx;
  logic          tx_nx;
  logic          accept;
  logic          bit_end;
  logic          stop_last;

  always_ff @(posedge comm_clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      shift      <= '0;
      hold       <= '0;
      hold_valid <= 1'b0;
      tx_pin     <= 1'b1;
    end else begin
      state      <= state_nx;
      baud_cnt   <= baud_cnt_nx;
      bit_cnt    <= bit_cnt_nx;
      stop_cnt   <= stop_cnt_nx;
      shift      <= shift_nx;
      hold       <= hold_nx;
      hold_valid <= hold_valid_nx;
      tx_pin     <= tx_nx;
    end
  end

  assign accept    = send && !hold_valid;
  assign bit_end   = (baud_cnt == BAUD_LAST);
  // With one stop bit the stop counter never gates the end of the frame.
  assign stop_last = bit_end && ((STOP_BITS == 1) || stop_cnt);

  always_comb begin
    state_nx      = state;
    baud_cnt_nx   = baud_cnt;
    bit_cnt_nx    = bit_cnt;
    stop_cnt_nx   = stop_cnt;
    shift_nx      = shift;
    hold_nx       = hold;
    hold_valid_nx = hold_valid;
    tx_nx         = tx_pin;

    if (accept) begin
      hold_nx       = data_in;
      hold_valid_nx = 1'b1;
    end

    case (state)
      IDLE: begin
        tx_nx       = 1'b1;
        baud_cnt_nx = '0;
        if (hold_valid) begin
          shift_nx      = hold;
          hold_valid_nx = 1'b0;
          state_nx      = START_BIT;
          tx_nx         = 1'b0;
        end
      end
      START_BIT: begin
        baud_cnt_nx = baud_cnt + 1'b1;
        if (bit_end) begin
          baud_cnt_nx = '0;
          bit_cnt_nx  = '0;
          state_nx    = DATA_BIT;
          tx_nx       = shift[0];
        end
      end
      DATA_BIT: begin
        baud_cnt_nx = baud_cnt + 1'b1;
        if (bit_end) begin
          baud_cnt_nx = '0;
          shift_nx    = {1'b0, shift[7:1]};
          bit_cnt_nx  = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_nx    = STOP_BIT;
            stop_cnt_nx = 1'b0;
            tx_nx       = 1'b1;
          end else begin
            tx_nx = shift[1];
          end
        end
      end
      STOP_BIT: begin
        baud_cnt_nx = baud_cnt + 1'b1;
        tx_nx       = 1'b1;
        if (bit_end) begin
          baud_cnt_nx = '0;
          stop_cnt_nx = ~stop_cnt;
        end
        // A waiting byte chains straight into the next start bit.
        if (stop_last) begin
          stop_cnt_nx = 1'b0;
          if (hold_valid) begin
            shift_nx      = hold;
            hold_valid_nx = 1'b0;
            state_nx      = START_BIT;
            tx_nx         = 1'b0;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        tx_nx    = 1'b1;
      end
    endcase
  end

  assign ready = !hold_valid;
  assign busy  = (state != IDLE) || hold_valid;

endmodule

// File: tb/tb_usart_tx.sv
// tb/tb_usart_tx.sv - self-checking bench for usart_tx
// Two instances: index 0 uses one stop bit, index 1 uses two.
module tb_usart_tx;

  localparam int CPB = 16;

  logic       comm_clock = 1'b0;
  logic       reset_n    = 1'b0;
  logic [1:0] send       = 2'b00;
  logic [7:0] data_in [2];
  logic [1:0] ready;
  logic [1:0] busy;
  logic [1:0] tx;

  int tests  = 0;
  int failed = 0;

  int         first_acc;
  bit         obs_q[$];
  bit         rdy_q[$];
  bit         bsy_q[$];
  bit         exp_q[$];
  logic [7:0] pend_q[$];

  always #5 comm_clock = ~comm_clock;

  usart_tx #(.CLOCKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
    .comm_clock(comm_clock), .reset_n(reset_n), .data_in(data_in[0]), .send(send[0]),
    .ready(ready[0]), .busy(busy[0]), .tx_pin(tx[0])
  );

  usart_tx #(.CLOCKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .comm_clock(comm_clock), .reset_n(reset_n), .data_in(data_in[1]), .send(send[1]),
    .ready(ready[1]), .busy(busy[1]), .tx_pin(tx[1])
  );

  // Reference line: start, 8 data bits LSB-first, stop bits, each CPB cycles long.
  task automatic model_frame(input logic [7:0] b, input int stops);
    repeat (CPB) exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (CPB) exp_q.push_back(b[i]);
    repeat (stops * CPB) exp_q.push_back(1'b1);
  endtask

  task automatic model_idle(input int n);
    repeat (n) exp_q.push_back(1'b1);
  endtask

  // Sample index k is taken k edges after the stream starts; first_acc is the accept edge.
  task automatic stream(input int d, input int total, input int delay, input bit junk);
    int edges;
    bit real_drv;
    edges     = 0;
    first_acc = -1;
    obs_q.delete(); rdy_q.delete(); bsy_q.delete();
    for (int c = 0; c < total; c++) begin
      obs_q.push_back(tx[d]);
      rdy_q.push_back(ready[d]);
      bsy_q.push_back(busy[d]);
      real_drv = 1'b0;
      if (pend_q.size() > 0 && ready[d] && (first_acc < 0 || edges + 1 >= first_acc + delay)) begin
        send[d]    = 1'b1;
        data_in[d] = pend_q.pop_front();
        real_drv   = 1'b1;
      end else if (junk && !ready[d]) begin
        send[d]    = 1'b1;
        data_in[d] = 8'h33;
      end else begin
        send[d] = 1'b0;
      end
      @(posedge comm_clock); #1;
      edges++;
      if (real_drv && first_acc < 0) first_acc = edges;
    end
    send[d] = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(posedge comm_clock);
    #1;
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (tx[d] !== 1'b1) begin failed++; $display("FAIL reset_tx[%0d]: got %b want 1", d, tx[d]); end
      tests++;
      if (ready[d] !== 1'b1) begin failed++; $display("FAIL reset_ready[%0d]: got %b want 1", d, ready[d]); end
      tests++;
      if (busy[d] !== 1'b0) begin failed++; $display("FAIL reset_busy[%0d]: got %b want 0", d, busy[d]); end
    end
    reset_n = 1'b1;
    @(posedge comm_clock); #1;
  endtask

  task automatic test_single;
    int mism, bad;
    exp_q.delete();
    model_frame(8'h55, 1);
    model_idle(8);
    pend_q = '{8'h55};
    stream(0, exp_q.size() + 10, 0, 1'b0);
    tests++;
    if (obs_q[first_acc] !== 1'b1) begin failed++; $display("FAIL single_idle_at_accept: got %b want 1", obs_q[first_acc]); end
    tests++;
    if (obs_q[first_acc + 1] !== 1'b0) begin failed++; $display("FAIL single_start_latency: got %b want 0", obs_q[first_acc + 1]); end
    tests++;
    if (rdy_q[first_acc] !== 1'b0) begin failed++; $display("FAIL single_ready_low: got %b want 0", rdy_q[first_acc]); end
    tests++;
    if (rdy_q[first_acc + 1] !== 1'b1) begin failed++; $display("FAIL single_ready_back: got %b want 1", rdy_q[first_acc + 1]); end
    tests++;
    if (bsy_q[first_acc + 160] !== 1'b1) begin failed++; $display("FAIL single_busy_last: got %b want 1", bsy_q[first_acc + 160]); end
    tests++;
    if (bsy_q[first_acc + 161] !== 1'b0) begin failed++; $display("FAIL single_busy_fall: got %b want 0", bsy_q[first_acc + 161]); end
    mism = 0; bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (obs_q[first_acc + 1 + i] !== exp_q[i]) begin mism++; if (bad < 0) bad = i; end
    tests++;
    if (first_acc < 0 || mism != 0) begin
      failed++; $display("FAIL single_wave: accept_edge %0d, %0d wrong cycles, first at %0d, want 0 wrong", first_acc, mism, bad);
    end
  endtask

  task automatic test_back_to_back;
    int mism, bad;
    exp_q.delete();
    model_frame(8'hA3, 1);
    model_frame(8'h0F, 1);
    model_idle(8);
    pend_q = '{8'hA3, 8'h0F};
    stream(0, exp_q.size() + 10, 0, 1'b0);
    mism = 0; bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (obs_q[first_acc + 1 + i] !== exp_q[i]) begin mism++; if (bad < 0) bad = i; end
    tests++;
    if (first_acc < 0 || mism != 0) begin
      failed++; $display("FAIL b2b_wave: accept_edge %0d, %0d wrong cycles, first at %0d, want 0 wrong", first_acc, mism, bad);
    end
  endtask

  task automatic test_ignored_send;
    int mism, bad;
    exp_q.delete();
    model_frame(8'h11, 1);
    model_frame(8'h22, 1);
    model_idle(40);
    pend_q = '{8'h11, 8'h22};
    stream(0, exp_q.size() + 10, 0, 1'b1);
    mism = 0; bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (obs_q[first_acc + 1 + i] !== exp_q[i]) begin mism++; if (bad < 0) bad = i; end
    tests++;
    if (first_acc < 0 || mism != 0) begin
      failed++; $display("FAIL ignored_wave: accept_edge %0d, %0d wrong cycles, first at %0d, want 0 wrong", first_acc, mism, bad);
    end
  endtask

  task automatic test_send_on_last_stop;
    int mism, bad;
    exp_q.delete();
    model_frame(8'hC6, 1);
    model_idle(1);
    model_frame(8'h39, 1);
    model_idle(8);
    pend_q = '{8'hC6, 8'h39};
    stream(0, exp_q.size() + 10, 161, 1'b0);
    mism = 0; bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (obs_q[first_acc + 1 + i] !== exp_q[i]) begin mism++; if (bad < 0) bad = i; end
    tests++;
    if (first_acc < 0 || mism != 0) begin
      failed++; $display("FAIL last_stop_wave: accept_edge %0d, %0d wrong cycles, first at %0d, want 0 wrong", first_acc, mism, bad);
    end
  endtask

  task automatic test_two_stop;
    int mism, bad;
    exp_q.delete();
    model_frame(8'hFF, 2);
    model_idle(8);
    pend_q = '{8'hFF};
    stream(1, exp_q.size() + 10, 0, 1'b0);
    tests++;
    if (bsy_q[first_acc + 176] !== 1'b1) begin failed++; $display("FAIL stop2_busy_last: got %b want 1", bsy_q[first_acc + 176]); end
    tests++;
    if (bsy_q[first_acc + 177] !== 1'b0) begin failed++; $display("FAIL stop2_busy_fall: got %b want 0", bsy_q[first_acc + 177]); end
    mism = 0; bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (obs_q[first_acc + 1 + i] !== exp_q[i]) begin mism++; if (bad < 0) bad = i; end
    tests++;
    if (first_acc < 0 || mism != 0) begin
      failed++; $display("FAIL stop2_wave: accept_edge %0d, %0d wrong cycles, first at %0d, want 0 wrong", first_acc, mism, bad);
    end
  endtask

  task automatic test_random_two_stop;
    int mism, bad;
    logic [7:0] b;
    exp_q.delete();
    pend_q.delete();
    for (int k = 0; k < 6; k++) begin
      b = 8'($urandom_range(0, 255));
      pend_q.push_back(b);
      model_frame(b, 2);
    end
    model_idle(8);
    stream(1, exp_q.size() + 10, 0, 1'b0);
    mism = 0; bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (obs_q[first_acc + 1 + i] !== exp_q[i]) begin mism++; if (bad < 0) bad = i; end
    tests++;
    if (first_acc < 0 || mism != 0) begin
      failed++; $display("FAIL rand_stop2_wave: accept_edge %0d, %0d wrong cycles, first at %0d, want 0 wrong", first_acc, mism, bad);
    end
  endtask

  task automatic test_reset_mid_frame;
    int mism, bad, highs;
    send[0] = 1'b1; data_in[0] = 8'h00;
    @(posedge comm_clock); #1;
    send[0] = 1'b0;
    @(posedge comm_clock); #1;
    send[0] = 1'b1; data_in[0] = 8'h5A;
    @(posedge comm_clock); #1;
    send[0] = 1'b0;
    repeat (87) @(posedge comm_clock);
    #1;
    tests++;
    if (tx[0] !== 1'b0) begin failed++; $display("FAIL midreset_bit4: got %b want 0", tx[0]); end
    tests++;
    if (ready[0] !== 1'b0) begin failed++; $display("FAIL midreset_hold_full: got %b want 0", ready[0]); end
    reset_n = 1'b0;
    @(posedge comm_clock); #1;
    reset_n = 1'b1;
    tests++;
    if (tx[0] !== 1'b1) begin failed++; $display("FAIL midreset_tx: got %b want 1", tx[0]); end
    tests++;
    if (ready[0] !== 1'b1) begin failed++; $display("FAIL midreset_ready: got %b want 1", ready[0]); end
    tests++;
    if (busy[0] !== 1'b0) begin failed++; $display("FAIL midreset_busy: got %b want 0", busy[0]); end
    pend_q.delete();
    stream(0, 200, 0, 1'b0);
    highs = 0;
    foreach (obs_q[i]) if (obs_q[i] === 1'b1) highs++;
    tests++;
    if (highs != 200) begin failed++; $display("FAIL midreset_hold_dropped: high cycles %0d want 200", highs); end
    exp_q.delete();
    model_frame(8'h81, 1);
    model_idle(8);
    pend_q = '{8'h81};
    stream(0, exp_q.size() + 10, 0, 1'b0);
    mism = 0; bad = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (obs_q[first_acc + 1 + i] !== exp_q[i]) begin mism++; if (bad < 0) bad = i; end
    tests++;
    if (first_acc < 0 || mism != 0) begin
      failed++; $display("FAIL midreset_after_wave: accept_edge %0d, %0d wrong cycles, first at %0d, want 0 wrong", first_acc, mism, bad);
    end
  endtask

  // Mid-bit sampling receiver over a shuffled sweep of every byte value.
  task automatic test_loopback_sweep;
    logic [7:0] sent [256];
    logic [7:0] tmp, rx;
    int j, o;
    bit frame_err;
    for (int i = 0; i < 256; i++) sent[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = sent[i]; sent[i] = sent[j]; sent[j] = tmp;
    end
    pend_q.delete();
    for (int i = 0; i < 256; i++) pend_q.push_back(sent[i]);
    stream(0, 256 * 160 + 20, 0, 1'b0);
    for (int f = 0; f < 256; f++) begin
      o = first_acc + 1 + f * 160;
      frame_err = (obs_q[o + CPB / 2] !== 1'b0) || (obs_q[o + 9 * CPB + CPB / 2] !== 1'b1);
      for (int i = 0; i < 8; i++) rx[i] = obs_q[o + (1 + i) * CPB + CPB / 2];
      tests++;
      if (first_acc < 0 || frame_err || rx !== sent[f]) begin
        failed++; $display("FAIL loopback[%0d]: got %02h framing_err %0d want %02h framing_err 0", f, rx, frame_err, sent[f]);
      end
    end
  endtask

  initial begin
    data_in[0] = 8'h00;
    data_in[1] = 8'h00;
    test_reset;
    test_single;
    test_back_to_back;
    test_ignored_send;
    test_send_on_last_stop;
    test_two_stop;
    test_random_two_stop;
    test_reset_mid_frame;
    test_loopback_sweep;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
